// File: rtl/sim_test_monitor.sv
// End-of-test monitor: detects riscv-tests tohost completion, runs a cycle
// watchdog and buffers nonzero-rd writebacks in a poppable trace FIFO.
module sim_test_monitor #(
  parameter int          NUM_CH      = 2,
  parameter int          TRACE_DEPTH = 16,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int          TIMEOUT     = 45000,
  localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int         ENTRY_W     = CH_W + 5 + 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [NUM_CH-1:0]     WB_VALID,
  input  logic [5*NUM_CH-1:0]   WB_RD,
  input  logic [32*NUM_CH-1:0]  WB_DATA,
  input  logic                  MEM_W_VALID,
  input  logic [31:0]           MEM_W_ADDR,
  input  logic [3:0]            MEM_W_STRB,
  input  logic [31:0]           MEM_W_DATA,
  input  logic                  TRACE_RDEN,
  output logic                  TRACE_RVALID,
  output logic [ENTRY_W-1:0]    TRACE_RDATA,
  output logic                  TRACE_OVERFLOW,
  output logic                  DONE,
  output logic                  PASS,
  output logic                  TIMED_OUT,
  output logic [30:0]           FAIL_CODE,
  output logic [31:0]           CYCLE_COUNT,
  output logic [31:0]           RETIRE_COUNT,
  output logic [31:0]           STAT
);

  localparam int          AW         = $clog2(TRACE_DEPTH);
  localparam int          CW         = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(TRACE_DEPTH);
  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [31:0]        cycle_q, cycle_d;
  logic [31:0]        retire_q, retire_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               tmo_q, tmo_d;
  logic [30:0]        fcode_q, fcode_d;
  logic               ovf_q, ovf_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               rvalid_q, rvalid_d;
  logic [ENTRY_W-1:0] rdata_q, rdata_d;
  logic [31:0]        stat_q, stat_d;
  logic [ENTRY_W-1:0] mem_q [TRACE_DEPTH];

  logic               run_s, start_run_s, hit_s, tmo_s, fin_s;
  logic               wr_ok_s, drop_s, pop_s;
  logic [NUM_CH-1:0]  elig_s;
  logic [CW-1:0]      off_s [NUM_CH];
  logic [CW-1:0]      k_s, free_s;
  logic [AW-1:0]      widx_s [NUM_CH];
  logic [ENTRY_W-1:0] entry_s [NUM_CH];
  logic [31:0]        cnt32_s;
  logic [7:0]         cnt_sat_s;

  // Event decode: tohost hit, watchdog expiry, eligibility and FIFO slot placement
  always_comb begin
    run_s       = (state_q == S_RUN);
    start_run_s = START && (state_q != S_RUN);
    hit_s       = run_s && MEM_W_VALID && (MEM_W_ADDR == TOHOST_ADDR) &&
                  (MEM_W_STRB == 4'hF) && (MEM_W_DATA != 32'd0);
    tmo_s       = run_s && !hit_s && (cycle_q == TIMEOUT_M1);
    fin_s       = hit_s || tmo_s;
    k_s         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig_s[i]  = WB_VALID[i] && (WB_RD[5*i +: 5] != 5'd0);
      off_s[i]   = k_s;
      widx_s[i]  = wr_ptr_q + off_s[i][AW-1:0];
      entry_s[i] = {CH_W'(i), WB_RD[5*i +: 5], WB_DATA[32*i +: 32]};
      if (elig_s[i]) begin
        k_s = k_s + CW'(1);
      end else begin
        k_s = k_s;
      end
    end
    // Space is judged on start-of-cycle occupancy; a same-cycle pop never helps
    free_s  = DEPTH_C - count_q;
    wr_ok_s = run_s && (k_s <= free_s);
    drop_s  = run_s && (k_s > free_s);
    pop_s   = TRACE_RDEN && (count_q != '0) && !start_run_s;
  end

  // Next-state for the FSM, counters, result flags and FIFO bookkeeping
  always_comb begin
    state_d  = state_q;
    cycle_d  = cycle_q;
    retire_d = retire_q;
    done_d   = done_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    fcode_d  = fcode_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rvalid_d = pop_s;
    rdata_d  = rdata_q;

    case (state_q)
      S_IDLE:  if (START) state_d = S_RUN; else state_d = S_IDLE;
      S_RUN:   if (fin_s) state_d = S_FIN; else state_d = S_RUN;
      S_FIN:   if (START) state_d = S_RUN; else state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase

    if (start_run_s) begin
      cycle_d  = 32'd0;
      retire_d = 32'd0;
      done_d   = 1'b0;
      pass_d   = 1'b0;
      tmo_d    = 1'b0;
      fcode_d  = 31'd0;
      ovf_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (run_s) begin
      if (!fin_s && (cycle_q != 32'hFFFF_FFFF)) begin
        cycle_d = cycle_q + 32'd1;
      end else begin
        cycle_d = cycle_q;
      end
      retire_d = retire_q + 32'(k_s);
      if (drop_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      if (hit_s) begin
        done_d  = 1'b1;
        pass_d  = (MEM_W_DATA == 32'd1);
        fcode_d = (MEM_W_DATA == 32'd1) ? 31'd0 : MEM_W_DATA[31:1];
      end else if (tmo_s) begin
        done_d = 1'b1;
        pass_d = 1'b0;
        tmo_d  = 1'b1;
      end else begin
        done_d = done_q;
      end
    end else begin
      cycle_d = cycle_q;
    end

    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + k_s[AW-1:0];
    end else begin
      wr_ptr_d = wr_ptr_d;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      rdata_d  = mem_q[rd_ptr_q];
    end else begin
      rdata_d  = rdata_q;
    end
    if (!start_run_s) begin
      count_d = count_q + (wr_ok_s ? k_s : CW'(0)) - (pop_s ? CW'(1) : CW'(0));
    end else begin
      count_d = '0;
    end

    cnt32_s   = 32'(count_d);
    cnt_sat_s = (cnt32_s > 32'd255) ? 8'hFF : cnt32_s[7:0];
    stat_d    = {fcode_d[15:0], cnt_sat_s, 2'b00, state_d, ovf_d, tmo_d, pass_d, done_d};
  end

  // State and status registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cycle_q  <= 32'd0;
      retire_q <= 32'd0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
      fcode_q  <= 31'd0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      stat_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
      fcode_q  <= fcode_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      stat_q   <= stat_d;
    end
  end

  // Trace storage; entries land in ascending channel order from the write pointer
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ok_s && elig_s[i]) begin
        mem_q[widx_s[i]] <= entry_s[i];
      end
    end
  end

  assign TRACE_RVALID   = rvalid_q;
  assign TRACE_RDATA    = rdata_q;
  assign TRACE_OVERFLOW = ovf_q;
  assign DONE           = done_q;
  assign PASS           = pass_q;
  assign TIMED_OUT      = tmo_q;
  assign FAIL_CODE      = fcode_q;
  assign CYCLE_COUNT    = cycle_q;
  assign RETIRE_COUNT   = retire_q;
  assign STAT           = stat_q;

endmodule

// File: tb/tb_sim_test_monitor.sv
// Directed bench for sim_test_monitor; trace pops are checked by a scoreboard
// monitor decoupled from the stimulus sequence.
module tb_sim_test_monitor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [1:0]  WB_VALID;
  logic [9:0]  WB_RD;
  logic [63:0] WB_DATA;
  logic        MEM_W_VALID;
  logic [31:0] MEM_W_ADDR;
  logic [3:0]  MEM_W_STRB;
  logic [31:0] MEM_W_DATA;
  logic        TRACE_RDEN;
  logic        TRACE_RVALID;
  logic [37:0] TRACE_RDATA;
  logic        TRACE_OVERFLOW;
  logic        DONE;
  logic        PASS;
  logic        TIMED_OUT;
  logic [30:0] FAIL_CODE;
  logic [31:0] CYCLE_COUNT;
  logic [31:0] RETIRE_COUNT;
  logic [31:0] STAT;

  int checks = 0;
  int passes = 0;
  logic [37:0] expq [$];
  logic [37:0] exp_e;

  sim_test_monitor #(
    .NUM_CH(2), .TRACE_DEPTH(4), .TOHOST_ADDR(32'h0000_1000), .TIMEOUT(20)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
    .MEM_W_VALID(MEM_W_VALID), .MEM_W_ADDR(MEM_W_ADDR),
    .MEM_W_STRB(MEM_W_STRB), .MEM_W_DATA(MEM_W_DATA),
    .TRACE_RDEN(TRACE_RDEN), .TRACE_RVALID(TRACE_RVALID), .TRACE_RDATA(TRACE_RDATA),
    .TRACE_OVERFLOW(TRACE_OVERFLOW), .DONE(DONE), .PASS(PASS), .TIMED_OUT(TIMED_OUT),
    .FAIL_CODE(FAIL_CODE), .CYCLE_COUNT(CYCLE_COUNT), .RETIRE_COUNT(RETIRE_COUNT),
    .STAT(STAT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    START = 1'b0; WB_VALID = 2'b00; WB_RD = 10'd0; WB_DATA = 64'd0;
    MEM_W_VALID = 1'b0; MEM_W_ADDR = 32'd0; MEM_W_STRB = 4'h0; MEM_W_DATA = 32'd0;
    TRACE_RDEN = 1'b0;
  endtask

  task automatic wb(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                    input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    WB_VALID = {v1, v0}; WB_RD = {r1, r0}; WB_DATA = {d1, d0};
  endtask

  task automatic st(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    MEM_W_VALID = 1'b1; MEM_W_ADDR = a; MEM_W_STRB = s; MEM_W_DATA = d;
  endtask

  task automatic start_run();
    idle_in(); START = 1'b1; tick(); START = 1'b0;
  endtask

  // Scoreboard monitor: every presented trace entry must match the oldest expectation
  always @(negedge CLK) begin
    if (TRACE_RVALID) begin
      if (expq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pop: got 0x%0h required no entry", TRACE_RDATA);
      end else begin
        exp_e = expq.pop_front();
        chk("trace_pop", {26'd0, TRACE_RDATA}, {26'd0, exp_e});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL time_limit: got timeout required completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    idle_in(); RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    chk("rst_stat", {32'd0, STAT}, 64'd0);
    chk("rst_done", {63'd0, DONE}, 64'd0);
    chk("rst_cycle", {32'd0, CYCLE_COUNT}, 64'd0);

    // Pass: START, three plain cycles, then tohost <- 1
    start_run();
    tick(); tick(); tick();
    st(32'h0000_1000, 4'hF, 32'd1); tick(); idle_in();
    chk("pass_stat", {32'd0, STAT}, 64'h0000_0023);
    chk("pass_cycle", {32'd0, CYCLE_COUNT}, 64'd3);
    tick(); tick();
    chk("pass_cycle_frozen", {32'd0, CYCLE_COUNT}, 64'd3);
    chk("pass_pass", {63'd0, PASS}, 64'd1);

    // Fail and filter
    start_run();
    chk("fail_restart_clear", {32'd0, STAT}, 64'h0000_0010);
    st(32'h0000_1000, 4'hF, 32'd0); tick();
    chk("zero_data_ignored", {63'd0, DONE}, 64'd0);
    st(32'h0000_1000, 4'h3, 32'h0000_000B); tick();
    chk("partial_strb_ignored", {32'd0, STAT}, 64'h0000_0010);
    st(32'h0000_1000, 4'hF, 32'h0000_000B); tick(); idle_in();
    chk("fail_code", {33'd0, FAIL_CODE}, 64'd5);
    chk("fail_stat", {32'd0, STAT}, 64'h0005_0021);

    // Trace with x0 filtering
    start_run();
    wb(1'b1, 5'd3, 32'h0000_00AA, 1'b1, 5'd0, 32'h0000_0055);
    expq.push_back({1'b0, 5'd3, 32'h0000_00AA});
    tick(); idle_in(); tick();
    chk("x0_retire", {32'd0, RETIRE_COUNT}, 64'd1);
    chk("x0_stat_count", {32'd0, STAT}, 64'h0000_0110);
    TRACE_RDEN = 1'b1; tick(); TRACE_RDEN = 1'b0; tick();
    chk("x0_after_pop", {32'd0, STAT}, 64'h0000_0010);
    st(32'h0000_1000, 4'hF, 32'd1); tick(); idle_in();

    // Timeout with no store
    start_run();
    n = 0;
    while (!DONE && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, 64'd20);
    chk("tmo_cycle_count", {32'd0, CYCLE_COUNT}, 64'd19);
    chk("tmo_stat", {32'd0, STAT}, 64'h0000_0025);

    // Hit coinciding with timeout wins
    start_run();
    for (int i = 0; i < 19; i++) tick();
    chk("coin_pre_done", {63'd0, DONE}, 64'd0);
    st(32'h0000_1000, 4'hF, 32'd1); tick(); idle_in();
    chk("coin_stat", {32'd0, STAT}, 64'h0000_0023);
    chk("coin_cycle", {32'd0, CYCLE_COUNT}, 64'd19);

    // Overflow on a depth-4 FIFO
    start_run();
    wb(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'd0); expq.push_back({1'b0, 5'd1, 32'h11}); tick();
    wb(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h22); expq.push_back({1'b1, 5'd2, 32'h22}); tick();
    wb(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0); expq.push_back({1'b0, 5'd3, 32'h33}); tick();
    wb(1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55); tick(); idle_in();
    chk("ovf_stat", {32'd0, STAT}, 64'h0000_0318);
    chk("ovf_retire", {32'd0, RETIRE_COUNT}, 64'd5);
    TRACE_RDEN = 1'b1;
    wb(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77); tick(); idle_in();
    chk("pop_dual_stat", {32'd0, STAT}, 64'h0000_0218);
    chk("pop_dual_retire", {32'd0, RETIRE_COUNT}, 64'd7);
    TRACE_RDEN = 1'b1; tick(); tick(); tick(); TRACE_RDEN = 1'b0; tick();
    wb(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
    expq.push_back({1'b0, 5'd8, 32'h88}); expq.push_back({1'b1, 5'd9, 32'h99});
    tick(); idle_in();
    chk("wrap_stat", {32'd0, STAT}, 64'h0000_0218);
    TRACE_RDEN = 1'b1; tick(); tick(); TRACE_RDEN = 1'b0; tick();
    wb(1'b1, 5'd10, 32'hAB, 1'b0, 5'd0, 32'd0); tick(); idle_in();
    st(32'h0000_1000, 4'hF, 32'd1); tick(); idle_in();
    chk("fin_with_entry", {32'd0, STAT}, 64'h0000_012B);
    chk("fin_retire", {32'd0, RETIRE_COUNT}, 64'd10);

    // Restart clears flags and FIFO
    start_run();
    chk("restart_stat", {32'd0, STAT}, 64'h0000_0010);
    chk("restart_ovf", {63'd0, TRACE_OVERFLOW}, 64'd0);
    chk("restart_retire", {32'd0, RETIRE_COUNT}, 64'd0);
    TRACE_RDEN = 1'b1; tick(); TRACE_RDEN = 1'b0; tick();

    // Reset mid-RUN
    wb(1'b1, 5'd1, 32'h5A, 1'b0, 5'd0, 32'd0); tick(); idle_in();
    chk("mid_retire", {32'd0, RETIRE_COUNT}, 64'd1);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("rst2_stat", {32'd0, STAT}, 64'd0);
    chk("rst2_retire", {32'd0, RETIRE_COUNT}, 64'd0);
    chk("rst2_cycle", {32'd0, CYCLE_COUNT}, 64'd0);
    chk("rst2_flags", {58'd0, DONE, PASS, TIMED_OUT, TRACE_OVERFLOW, TRACE_RVALID, 1'b0}, 64'd0);
    chk("rst2_rdata", {26'd0, TRACE_RDATA}, 64'd0);
    TRACE_RDEN = 1'b1; tick(); TRACE_RDEN = 1'b0; tick(); tick();
    chk("scoreboard_drained", expq.size(), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sim_test_monitor.md
# sim_test_monitor

Parametrised end-of-test and writeback-trace monitor for the sasanqua simulation environment. Sits beside the core and MMU and samples N register-writeback channels plus the data-store channel. Detects riscv-tests `tohost` completion and reports pass/fail, enforces a cycle watchdog, and buffers writebacks in a readable trace FIFO. It replaces fixed-length runs that end in a blind `$stop`.

## Interface
- NUM_CH, 2: number of writeback channels sampled per cycle (1..4)
- TRACE_DEPTH, 16: trace FIFO entries; power of two, ≥ NUM_CH
- TOHOST_ADDR, 32'h0000_1000: store address that signals test completion
- TIMEOUT, 45000: watchdog limit in RUN cycles (≥ 2)
- CH_W, derived, max(1, clog2(NUM_CH)); ENTRY_W = CH_W+5+32

Ports:
- CLK  in  1  clock; all logic on the rising edge
- RST  in  1  reset; synchronous, active-high
- START  in  1  start/restart pulse
- WB_VALID  in  NUM_CH  per-channel writeback valid
- WB_RD  in  5*NUM_CH  destination register; channel i is at [5i+4:5i]
- WB_DATA  in  32*NUM_CH  writeback data; channel i is at [32i+31:32i]
- MEM_W_VALID  in  1  store valid
- MEM_W_ADDR  in  32  store address
- MEM_W_STRB  in  4  store byte strobes
- MEM_W_DATA  in  32  store data
- TRACE_RDEN  in  1  pop request
- TRACE_RVALID  out  1  popped entry valid
- TRACE_RDATA  out  ENTRY_W  {ch, rd, data}
- TRACE_OVERFLOW  out  1  sticky; trace entries were dropped
- DONE  out  1  test finished
- PASS  out  1  finished with `tohost`==1
- TIMED_OUT  out  1  finished by watchdog
- FAIL_CODE  out  31  `tohost`>>1 on fail
- CYCLE_COUNT  out  32  RUN cycles elapsed
- RETIRE_COUNT  out  32  accepted writebacks with rd≠0
- STAT  out  32  [0]DONE [1]PASS [2]TIMED_OUT [3]TRACE_OVERFLOW [5:4]state [15:8]FIFO count (saturating at 255) [31:16]FAIL_CODE[15:0]

## Operation
- States are IDLE=0, RUN=1 and FIN=2.
  - IDLE→RUN on START.
  - RUN→FIN on a `tohost` hit or on timeout.
  - FIN→RUN on START.
  - RUN ignores START.
- Entering RUN from either IDLE or FIN clears CYCLE_COUNT, RETIRE_COUNT, the FIFO, TRACE_OVERFLOW, DONE, PASS, TIMED_OUT and FAIL_CODE.
- A `tohost` hit is MEM_W_VALID && MEM_W_ADDR==TOHOST_ADDR && MEM_W_STRB==4'hF && MEM_W_DATA≠0, sampled in RUN.
  - Data 1 gives PASS=1.
  - Any other nonzero value gives PASS=0 and FAIL_CODE=DATA[31:1].
  - Partial-strobe or zero-data writes to the address are ignored.
- Timeout: in RUN with CYCLE_COUNT==TIMEOUT-1 and no hit this cycle → FIN with TIMED_OUT=1 and PASS=0. If a hit and timeout coincide, the hit wins.
- Trace write, RUN only:
  - Eligible entries are channels with WB_VALID=1 and rd≠0.
  - Let k be the number of eligible entries. If free slots ≥ k, all are written this cycle in ascending channel order.
  - Otherwise all k entries for that cycle are dropped and TRACE_OVERFLOW is set (sticky).
  - RETIRE_COUNT += k whether or not the entries were dropped.
- Free slots are computed from the occupancy at the start of the cycle. A same-cycle pop does not add space.
- Trace read is allowed in any state. TRACE_RDEN with FIFO non-empty pops the head. TRACE_RDEN on an empty FIFO has no effect and TRACE_RVALID stays 0.
- In FIN no writes, counting or hit detection occur. Outputs hold until START or RST.
- Pointers wrap modulo TRACE_DEPTH. A full FIFO has count==TRACE_DEPTH, and full and empty are distinguished by the count register.

## Timing
- Reset: every output is 0, state is IDLE and the FIFO is empty. RST mid-RUN aborts on the next edge with the same values.
- CYCLE_COUNT is 0 in the first RUN cycle and increments each RUN cycle. It saturates at all-ones and freezes in FIN.
- DONE, PASS, TIMED_OUT and FAIL_CODE update on the edge that samples the hit or timeout, so they are visible the cycle after.
- Trace read latency is 1 cycle: TRACE_RDEN at edge n gives TRACE_RVALID and TRACE_RDATA valid after edge n+1 for one cycle. TRACE_RDATA holds its last value otherwise.
- Back-to-back TRACE_RDEN pops one entry per cycle.
- STAT is registered, with the same cycle alignment as the other status outputs.

## Test plan
- Pass: START, then 3 cycles later a store of 1 to 0x1000 with STRB=F → next cycle DONE=1, PASS=1, STAT[1:0]=2'b11, CYCLE_COUNT=3 and frozen.
- Fail and filter:
  - A store of 0x1000←0 (ignored) and a store with STRB=4'h3 (ignored) keep the block in RUN.
  - Then 0x1000←0x0B → PASS=0, FAIL_CODE=5, STAT[31:16]=5.
- Timeout: TIMEOUT=20, no store → DONE and TIMED_OUT asserted after the edge with CYCLE_COUNT=19. A hit injected in the same cycle instead yields PASS=1 and TIMED_OUT=0.
- Trace with x0 filtering: NUM_CH=2, one cycle with ch0 {rd=3, 0xAA} and ch1 {rd=0} → RETIRE_COUNT=1. A pop then returns {ch=0, rd=3, 0xAA} one cycle after TRACE_RDEN.
- Overflow: TRACE_DEPTH=4, fill 3 entries, then one dual-channel cycle → both entries dropped, TRACE_OVERFLOW=1, count=3, RETIRE_COUNT=5. A pop plus a dual write in the same cycle is still dropped.
- Reset and restart: RST mid-RUN gives all outputs 0 and IDLE. START after FIN clears the flags and FIFO and returns to RUN.
